// File: rtl/spi_dev_cmd_mux_pkg.sv
// ---------------------------------------------------------------------------
// spi_dev_defs
//   Shared definitions for the SPI device command mux.
//   - state_e    : router state encoding (IDLE=0, ACTIVE=1, DISCARD=2)
//   - IDLE_RDATA : read byte returned when no target owns the transaction
//   - idx_width  : width of a port index for a given port count
// ---------------------------------------------------------------------------
package spi_dev_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam logic [7:0] IDLE_RDATA = 8'hFF;

    // A single-port build still needs a 1-bit index so the owner register exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_dev_cmd_mux_if.sv
// ---------------------------------------------------------------------------
// spi_dev_cmd_mux_if
//   Bundles the protocol-wrapper side (pw_*) and the command-target side (p_*)
//   of the command mux.
//   slave  : the mux view   (pw_* in, pw_rdata out, p_* out, p_rdata in)
//   master : the wrapper/target view (directions reversed)
// ---------------------------------------------------------------------------
interface spi_dev_cmd_mux_if #(
    parameter int N_PORTS = 4
);
    logic [7:0]           pw_wdata;
    logic                 pw_wcmd;
    logic                 pw_wstb;
    logic                 pw_end;
    logic                 pw_rstb;
    logic [7:0]           pw_rdata;

    logic [7:0]           p_wdata;
    logic [N_PORTS-1:0]   p_wstb;
    logic [N_PORTS-1:0]   p_sel;
    logic [N_PORTS-1:0]   p_end;
    logic [N_PORTS-1:0]   p_rstb;
    logic [8*N_PORTS-1:0] p_rdata;

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_rstb,
        output pw_rdata,
        output p_wdata, p_wstb, p_sel, p_end, p_rstb,
        input  p_rdata
    );

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_rstb,
        input  pw_rdata,
        input  p_wdata, p_wstb, p_sel, p_end, p_rstb,
        output p_rdata
    );
endinterface

// File: rtl/spi_dev_cmd_match.sv
// ---------------------------------------------------------------------------
// spi_dev_cmd_match
//   Combinational comparator of a command byte against the per-port command
//   table. When several ports share a command byte the lowest index wins.
//   wdata : command byte under test
//   hit   : some port owns this command byte
//   idx   : lowest matching port index (0 when no hit)
// ---------------------------------------------------------------------------
module spi_dev_cmd_match
    import spi_dev_defs::*;
#(
    parameter int                   N_PORTS  = 4,
    parameter logic [8*N_PORTS-1:0] CMD_LIST = 32'h03020100,
    parameter int                   IDX_W    = idx_width(N_PORTS)
) (
    input  logic [7:0]       wdata,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest matching index overwrite
    // any higher one, giving the priority encode without a separate pass.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (CMD_LIST[8*i +: 8] == wdata) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spi_dev_cmd_mux.sv
// ---------------------------------------------------------------------------
// spi_dev_cmd_mux
//   Routes one SPI transaction at a time from the protocol wrapper to the
//   command target selected by the first command byte. The owner keeps the
//   write and read byte streams until the transaction ends; unknown commands
//   are swallowed and counted.
//   clk, rst : clock and synchronous active-high reset
//   bus      : wrapper-side strobes/data and per-target strobes/data
//   byte_cnt : data bytes forwarded in the current transaction (saturating)
//   unk_cnt  : unknown commands seen since reset (saturating)
// ---------------------------------------------------------------------------
module spi_dev_cmd_mux
    import spi_dev_defs::*;
#(
    parameter int                   N_PORTS  = 4,
    parameter logic [8*N_PORTS-1:0] CMD_LIST = 32'h03020100,
    parameter int                   CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_dev_cmd_mux_if.slave    bus,
    output logic [CNT_W-1:0]    byte_cnt,
    output logic [CNT_W-1:0]    unk_cnt
);

    localparam int IDX_W = idx_width(N_PORTS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         p_wdata_q, p_wdata_d;
    logic [N_PORTS-1:0] p_wstb_q, p_wstb_d;
    logic [N_PORTS-1:0] p_sel_q, p_sel_d;
    logic [N_PORTS-1:0] p_end_q, p_end_d;
    logic [N_PORTS-1:0] p_rstb_q, p_rstb_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   unk_cnt_q, unk_cnt_d;

    logic               cmd_hit;
    logic [IDX_W-1:0]   cmd_idx;
    logic               is_cmd;
    logic               is_data;
    logic [7:0]         rdata_mux;

    assign is_cmd  = bus.pw_wstb &  bus.pw_wcmd;
    assign is_data = bus.pw_wstb & ~bus.pw_wcmd;

    spi_dev_cmd_match #(
        .N_PORTS  (N_PORTS),
        .CMD_LIST (CMD_LIST),
        .IDX_W    (IDX_W)
    ) u_match (
        .wdata (bus.pw_wdata),
        .hit   (cmd_hit),
        .idx   (cmd_idx)
    );

    // Next-state and output decode. Work is ordered the way the wrapper's
    // events are defined to resolve: first the byte for the current owner,
    // then a new command decode, and finally pw_end closing whatever is open.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        p_wdata_d  = p_wdata_q;
        p_wstb_d   = '0;
        p_sel_d    = '0;
        p_end_d    = '0;
        p_rstb_d   = '0;
        byte_cnt_d = byte_cnt_q;
        unk_cnt_d  = unk_cnt_q;

        if (state_q == ST_ACTIVE) begin
            if (is_data) begin
                p_wdata_d         = bus.pw_wdata;
                p_wstb_d[owner_q] = 1'b1;
                if (byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
            end
            if (bus.pw_rstb) begin
                p_rstb_d[owner_q] = 1'b1;
            end
            // A command byte mid-transaction is an implicit end for the owner.
            if (is_cmd || bus.pw_end) begin
                p_end_d[owner_q] = 1'b1;
            end
        end

        if (is_cmd) begin
            if (cmd_hit) begin
                state_d    = ST_ACTIVE;
                owner_d    = cmd_idx;
                byte_cnt_d = '0;
            end else begin
                state_d = ST_DISCARD;
                if (unk_cnt_q != '1) begin
                    unk_cnt_d = unk_cnt_q + CNT_W'(1);
                end
            end
        end

        // pw_end wins over a same-cycle command: that transaction never
        // becomes visible on p_sel.
        if (bus.pw_end) begin
            state_d = ST_IDLE;
        end

        if (state_d == ST_ACTIVE) begin
            p_sel_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            p_wdata_q  <= '0;
            p_wstb_q   <= '0;
            p_sel_q    <= '0;
            p_end_q    <= '0;
            p_rstb_q   <= '0;
            byte_cnt_q <= '0;
            unk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            p_wdata_q  <= p_wdata_d;
            p_wstb_q   <= p_wstb_d;
            p_sel_q    <= p_sel_d;
            p_end_q    <= p_end_d;
            p_rstb_q   <= p_rstb_d;
            byte_cnt_q <= byte_cnt_d;
            unk_cnt_q  <= unk_cnt_d;
        end
    end

    // Read data follows the registered owner combinationally, so a target's
    // byte must already be on p_rdata when pw_rstb is raised.
    always_comb begin
        rdata_mux = IDLE_RDATA;
        if (state_q == ST_ACTIVE) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    rdata_mux = bus.p_rdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.pw_rdata = rdata_mux;
    assign bus.p_wdata  = p_wdata_q;
    assign bus.p_wstb   = p_wstb_q;
    assign bus.p_sel    = p_sel_q;
    assign bus.p_end    = p_end_q;
    assign bus.p_rstb   = p_rstb_q;
    assign byte_cnt     = byte_cnt_q;
    assign unk_cnt      = unk_cnt_q;

endmodule

// File: tb/tb_spi_dev_cmd_mux.sv
// ---------------------------------------------------------------------------
// tb_spi_dev_cmd_mux
//   Two mux instances share one stimulus stream: A uses the default command
//   table (00,01,02,03), B has ports 1 and 2 both on 05 (00,05,05,03).
//   A transaction-level model (owner index or none, byte counters) predicts
//   every registered output each cycle; directed literal checks pin it.
// ---------------------------------------------------------------------------
module tb_spi_dev_cmd_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pw_wdata = 8'h00;
    logic       pw_wcmd  = 1'b0;
    logic       pw_wstb  = 1'b0;
    logic       pw_end   = 1'b0;
    logic       pw_rstb  = 1'b0;
    logic [7:0] prd [4] = '{8'h10, 8'h5A, 8'h32, 8'h43};

    logic [7:0] bc_a, uc_a, bc_b, uc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_dev_cmd_mux_if #(.N_PORTS(4)) if_a ();
    spi_dev_cmd_mux_if #(.N_PORTS(4)) if_b ();

    assign if_a.pw_wdata = pw_wdata;
    assign if_a.pw_wcmd  = pw_wcmd;
    assign if_a.pw_wstb  = pw_wstb;
    assign if_a.pw_end   = pw_end;
    assign if_a.pw_rstb  = pw_rstb;
    assign if_a.p_rdata  = {prd[3], prd[2], prd[1], prd[0]};
    assign if_b.pw_wdata = pw_wdata;
    assign if_b.pw_wcmd  = pw_wcmd;
    assign if_b.pw_wstb  = pw_wstb;
    assign if_b.pw_end   = pw_end;
    assign if_b.pw_rstb  = pw_rstb;
    assign if_b.p_rdata  = {prd[3], prd[2], prd[1], prd[0]};

    spi_dev_cmd_mux #(
        .N_PORTS(4), .CMD_LIST(32'h03020100), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .byte_cnt(bc_a), .unk_cnt(uc_a)
    );

    spi_dev_cmd_mux #(
        .N_PORTS(4), .CMD_LIST(32'h03050500), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .byte_cnt(bc_b), .unk_cnt(uc_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0] cmd_tab [2][4] = '{'{8'h00, 8'h01, 8'h02, 8'h03},
                                   '{8'h00, 8'h05, 8'h05, 8'h03}};
    int         m_owner [2] = '{-1, -1};   // -1: no target owns the transaction
    int         m_cnt   [2] = '{0, 0};
    int         m_unk   [2] = '{0, 0};
    logic [7:0] m_wdata [2] = '{8'h00, 8'h00};
    logic [3:0] e_wstb  [2];
    logic [3:0] e_end   [2];
    logic [3:0] e_rstb  [2];

    task automatic model_edge(input int k);
        int found;
        e_wstb[k] = 4'b0;
        e_end[k]  = 4'b0;
        e_rstb[k] = 4'b0;
        if (rst) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_unk[k]   = 0;
            m_wdata[k] = 8'h00;
            return;
        end
        if (m_owner[k] >= 0) begin
            if (pw_wstb && !pw_wcmd) begin
                e_wstb[k][m_owner[k]] = 1'b1;
                m_wdata[k] = pw_wdata;
                m_cnt[k]   = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
            end
            if (pw_rstb) e_rstb[k][m_owner[k]] = 1'b1;
            if ((pw_wstb && pw_wcmd) || pw_end) begin
                e_end[k][m_owner[k]] = 1'b1;
                m_owner[k] = -1;
            end
        end
        if (pw_wstb && pw_wcmd) begin
            found = -1;
            for (int i = 3; i >= 0; i--)
                if (cmd_tab[k][i] == pw_wdata) found = i;
            if (found >= 0) begin
                m_owner[k] = found;
                m_cnt[k]   = 0;
            end else begin
                m_unk[k] = (m_unk[k] < 255) ? m_unk[k] + 1 : 255;
            end
        end
        if (pw_end) m_owner[k] = -1;
    endtask

    task automatic compare(input int k, input string tag,
                           input logic [3:0] sel, input logic [3:0] wstb,
                           input logic [3:0] endp, input logic [3:0] rstb,
                           input logic [7:0] wd, input logic [7:0] bc,
                           input logic [7:0] uc, input logic [7:0] rd);
        logic [3:0] exp_sel;
        logic [7:0] exp_rd;
        exp_sel = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0;
        exp_rd  = (m_owner[k] >= 0) ? prd[m_owner[k]] : 8'hFF;
        check({tag, ".p_sel"},    32'(sel),  32'(exp_sel));
        check({tag, ".p_wstb"},   32'(wstb), 32'(e_wstb[k]));
        check({tag, ".p_end"},    32'(endp), 32'(e_end[k]));
        check({tag, ".p_rstb"},   32'(rstb), 32'(e_rstb[k]));
        check({tag, ".p_wdata"},  32'(wd),   32'(m_wdata[k]));
        check({tag, ".byte_cnt"}, 32'(bc),   32'(m_cnt[k]));
        check({tag, ".unk_cnt"},  32'(uc),   32'(m_unk[k]));
        check({tag, ".pw_rdata"}, 32'(rd),   32'(exp_rd));
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
        #1;
        compare(0, "A", if_a.p_sel, if_a.p_wstb, if_a.p_end, if_a.p_rstb,
                if_a.p_wdata, bc_a, uc_a, if_a.pw_rdata);
        compare(1, "B", if_b.p_sel, if_b.p_wstb, if_b.p_end, if_b.p_rstb,
                if_b.p_wdata, bc_b, uc_b, if_b.pw_rdata);
    end

    // ---------------- stimulus: one call = one clock cycle ----------------
    task automatic drive(input logic [7:0] d, input bit c, input bit w, input bit r, input bit e);
        @(negedge clk);
        pw_wdata = d;
        pw_wcmd  = c;
        pw_wstb  = w;
        pw_rstb  = r;
        pw_end   = e;
    endtask

    task automatic cmd(input logic [7:0] d);     drive(d, 1, 1, 0, 0); endtask
    task automatic dat(input logic [7:0] d);     drive(d, 0, 1, 0, 0); endtask
    task automatic cmd_end(input logic [7:0] d); drive(d, 1, 1, 0, 1); endtask
    task automatic dat_end(input logic [7:0] d); drive(d, 0, 1, 0, 1); endtask
    task automatic rd();                         drive(8'h00, 0, 0, 1, 0); endtask
    task automatic fin();                        drive(8'h00, 0, 0, 0, 1); endtask
    task automatic nop();                        drive(8'h00, 0, 0, 0, 0); endtask

    // Literal checks below run at a negedge and see the outputs produced by
    // the previous cycle's drive.
    initial begin
        repeat (2) nop();
        check("reset p_sel",    32'(if_a.p_sel), 32'h0);
        check("reset pw_rdata", 32'(if_a.pw_rdata), 32'hFF);
        check("reset byte_cnt", 32'(bc_a), 32'h0);
        check("reset unk_cnt",  32'(uc_a), 32'h0);
        rst = 1'b0;

        // Match
        cmd(8'h02);
        dat(8'hAA);  check("match sel",     32'(if_a.p_sel), 32'b0100);
        dat(8'hBB);  check("match wstb1",   32'(if_a.p_wstb), 32'b0100);
                     check("match wdata1",  32'(if_a.p_wdata), 32'hAA);
        fin();       check("match wdata2",  32'(if_a.p_wdata), 32'hBB);
        nop();       check("match end",     32'(if_a.p_end), 32'b0100);
                     check("match sel off", 32'(if_a.p_sel), 32'b0000);
                     check("match cnt",     32'(bc_a), 32'd2);

        // Unknown
        cmd(8'h7E);
        dat(8'h01);  check("unk rdata", 32'(if_a.pw_rdata), 32'hFF);
        dat(8'h02);  check("unk cnt",   32'(uc_a), 32'd1);
        dat(8'h03);
        rd();        check("unk wstb",  32'(if_a.p_wstb), 32'h0);
        rd();
        fin();       check("unk rstb",  32'(if_a.p_rstb), 32'h0);
        nop();       check("unk end",   32'(if_a.p_end), 32'h0);

        // Read
        cmd(8'h01);
        rd();        check("read rdata", 32'(if_a.pw_rdata), 32'h5A);
        rd();        check("read rstb1", 32'(if_a.p_rstb), 32'b0010);
        fin();       check("read rstb2", 32'(if_a.p_rstb), 32'b0010);
        nop();

        // Implicit end
        cmd(8'h00);
        dat(8'h11);  check("impl sel0",  32'(if_a.p_sel), 32'b0001);
        cmd(8'h03);
        dat(8'h22);  check("impl end0",  32'(if_a.p_end), 32'b0001);
                     check("impl sel3",  32'(if_a.p_sel), 32'b1000);
        fin();
        nop();

        // Same-cycle byte and end
        cmd_end(8'h03);
        nop();       check("cmd+end sel", 32'(if_a.p_sel), 32'h0);
                     check("cmd+end cnt", 32'(bc_a), 32'd0);
        cmd(8'h03);
        dat_end(8'h44);
        nop();       check("dat+end wstb", 32'(if_a.p_wstb), 32'b1000);
                     check("dat+end end",  32'(if_a.p_end), 32'b1000);
                     check("dat+end cnt",  32'(bc_a), 32'd1);
        cmd_end(8'h7E);
        nop();       check("unk+end cnt",  32'(uc_a), 32'd2);

        // Duplicate command byte and byte_cnt saturation
        cmd(8'h05);
        dat(8'h00);  check("dup owner", 32'(if_b.p_sel), 32'b0010);
                     check("dup A unk", 32'(uc_a), 32'd3);
        for (int i = 1; i < 300; i++) dat(8'(i));
        fin();       check("sat byte_cnt", 32'(bc_b), 32'd255);
        nop();

        // Reset mid-transaction
        cmd(8'h02);
        dat(8'h01);
        dat(8'h02);
        dat(8'h03);
        @(negedge clk);
        check("pre-rst cnt", 32'(bc_a), 32'd3);
        rst = 1'b1;
        pw_wstb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst sel",   32'(if_a.p_sel), 32'h0);
        check("rst end",   32'(if_a.p_end), 32'h0);
        check("rst cnt",   32'(bc_a), 32'h0);
        check("rst unk",   32'(uc_a), 32'h0);
        check("rst rdata", 32'(if_a.pw_rdata), 32'hFF);
        dat(8'h09);
        dat(8'h08);
        nop();       check("post-rst wstb", 32'(if_a.p_wstb), 32'h0);
                     check("post-rst cnt",  32'(bc_a), 32'h0);

        // unk_cnt saturation
        for (int i = 0; i < 260; i++) cmd(8'h7E);
        nop();       check("sat unk A", 32'(uc_a), 32'd255);
                     check("sat unk B", 32'(uc_b), 32'd255);
        nop();
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
